// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Turns a MEM-stage memory
// instruction into a req/ready transaction on a word-wide data port, formats
// load data into ReadDataM, and stalls the pipeline until the access completes,
// times out, or is rejected as misaligned or unsupported.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        ErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  // funct3 and byte offset are kept for formatting the load word on return
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic            op_legal;
  logic            op_misal;
  logic [3:0]      st_wstrb;
  logic [31:0]     st_wdata;

  // Select, align and extend the addressed byte/half from the returned word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                           input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    r = '0;
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Legality, alignment and store lane/strobe generation for the MEM-stage op.
  always_comb begin
    op_legal = 1'b0;
    op_misal = 1'b0;
    st_wstrb = '0;
    st_wdata = '0;

    if (MemWriteM) begin
      op_legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
    end else begin
      op_legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
                 (Funct3M == 3'b100) || (Funct3M == 3'b101);
    end

    op_misal = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
               ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));

    case (Funct3M[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ALUResultM[1:0];
        st_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
        st_wdata = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        st_wstrb = 4'b1111;
        st_wdata = WriteDataM;
      end
      default: begin
        st_wstrb = '0;
        st_wdata = '0;
      end
    endcase
  end

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;

    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          if (op_legal && !op_misal) begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            wdata_d = MemWriteM ? st_wdata : '0;
            wstrb_d = MemWriteM ? st_wstrb : '0;
            f3_d    = Funct3M;
            off_d   = ALUResultM[1:0];
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = fmt_load(f3_q, off_q, mem_rdata);
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset abandons any access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  // Stall covers the IDLE request cycle and all of BUSY; DONE releases the pipeline.
  assign StallM    = reset && (((state_q == IDLE) && MemReqM) || (state_q == BUSY));
  assign ReadDataM = rdata_q;
  assign ErrM      = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit in the MEM stage of the 5-stage RV32I pipeline. It produces ReadDataM, the value the MEM/WB register captures for loads. It converts a MEM-stage memory instruction into a req/ready transaction on a word-wide data-memory port, and aligns and extends load data. It holds the pipeline with StallM until the access completes, times out, or is rejected as misaligned or unsupported.

Parameters:
TIMEOUT, 255, maximum BUSY cycles to wait for mem_ready before aborting (1..2^TO_W-1)
TO_W, 8, width of the timeout counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge)
MemReqM  in  1  a load or store occupies MEM this cycle
MemWriteM  in  1  1=store, 0=load
Funct3M  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
ALUResultM  in  32  effective byte address
WriteDataM  in  32  store source (rs2)
ReadDataM  out  32  registered, aligned/extended load result
StallM  out  1  combinational; freezes IF..MEM and bubbles MEM/WB
ErrM  out  1  registered one-cycle pulse: misaligned, bad funct3 or timeout
mem_req  out  1  registered request valid
mem_we  out  1  registered write enable
mem_addr  out  32  registered word address {ALUResultM[31:2],2'b00}
mem_wdata  out  32  registered lane-replicated store data
mem_wstrb  out  4  registered byte strobes (0000 on loads)
mem_ready  in  1  memory accepted/completed request this cycle
mem_rdata  in  32  read word, valid when mem_ready=1

Behaviour:
- Reset (reset==0 at edge): state=IDLE, timeout counter=0, ReadDataM=0, ErrM=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. StallM=0 while reset==0. If a transaction is outstanding, it is abandoned and a late mem_ready is ignored.
- Legal ops: loads use Funct3 000/001/010/100/101; stores use 000/001/010. Any other code is illegal.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- States: IDLE, BUSY, DONE.
- IDLE, MemReqM=0: StallM=0, nothing changes.
- IDLE, MemReqM=1, legal and aligned:
  - StallM=1.
  - Next edge: BUSY, mem_req=1, mem_we/addr/wdata/wstrb latched, counter=0.
- IDLE, MemReqM=1, illegal or misaligned:
  - StallM=1, no memory request.
  - Next edge: DONE, ErrM=1.
- BUSY: StallM=1. mem_req and all mem_* outputs are held stable until the mem_ready edge.
  - mem_ready=1: mem_req<=0, state<=DONE. For a load, ReadDataM<=formatted mem_rdata. For a store, ReadDataM is unchanged.
  - mem_ready=0, counter==TIMEOUT-1: mem_req<=0, ErrM<=1, ReadDataM<=0 for a load, state<=DONE.
  - Otherwise: counter+1.
- DONE: StallM=0 for exactly one cycle so MEM/WB captures ReadDataM. ErrM stays high for this cycle only. MemReqM still high in DONE belongs to the same instruction and is never restarted. Next edge: IDLE, ErrM<=0.
- Minimum access: 3 cycles (IDLE, BUSY with mem_ready, DONE), StallM high for 2. A back-to-back memory instruction starts in the following IDLE cycle.
- Load formatting (byte select = addr[1:0]):
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the half selected by addr[1]. LHU: zero-extend it.
  - LW: whole word.
- Store strobes/data:
  - SB: wstrb=0001<<addr[1:0], wdata = byte replicated to all 4 lanes.
  - SH: wstrb=0011<<(2*addr[1]), wdata = half replicated to both halves.
  - SW: wstrb=1111, wdata=WriteDataM.
- mem_ready outside BUSY is ignored.
- Reset during BUSY: the next edge forces IDLE with mem_req=0, regardless of mem_ready in that cycle.

Test Plan:
- LW, addr 0x0000_0010, mem_ready at 1st BUSY cycle, rdata 0xDEADBEEF -> mem_addr 0x10, wstrb 0000; StallM 1,1,0; ReadDataM 0xDEADBEEF in DONE; ErrM 0.
- LB/LBU, addr 0x...13, rdata 0x80FF_1234 -> LB ReadDataM 0xFFFFFF80; LBU 0x00000080. LH/LHU, addr 0x...12 -> 0xFFFF80FF / 0x000080FF.
- SB, addr 0x...21, WriteDataM 0x000000AB; SH, addr 0x...22, WriteDataM 0x0000BEEF -> SB: wstrb 0010, wdata 0xABABABAB, mem_we 1. SH: wstrb 1100, wdata 0xBEEFBEEF. ReadDataM unchanged after both.
- LW at 0x...02; SH at 0x...01; funct3 011 -> no mem_req; one stall cycle; ErrM pulse 1 cycle in DONE.
- TIMEOUT=4, mem_ready held 0 -> mem_req high for exactly 4 cycles; then DONE with ErrM=1 and ReadDataM=0. A late mem_ready is ignored.
- Reset (reset=0) in 2nd BUSY cycle with mem_ready=1 -> next edge IDLE, mem_req 0, ReadDataM 0. After release, a new LW completes normally in 3 cycles.
